// File: rtl/microwave_timer_ctrl_pkg.sv
// ============================================================================
// Module   : microwave_timer_ctrl_pkg
// Purpose  : Shared state encoding and BCD digit limits for the cook-time
//            controller and its m:ss decrementer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package microwave_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;
  localparam logic [3:0] BCD_MAX_MIN  = 4'd9;

endpackage

`default_nettype wire

// File: rtl/microwave_timer_ctrl_mmss_bcd_dec.sv
// ============================================================================
// Module   : mmss_bcd_dec
// Purpose  : Combinational one-second decrement of an m:ss BCD time with
//            borrow (ones 0->9 borrows tens, tens 0->5 borrows minutes).
// Ports    : min_i/s_tens_i/s_ones_i  - current time digits
//            min_o/s_tens_o/s_ones_o  - decremented time digits
//            is_zero_o                - decremented result equals 0:00
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmss_bcd_dec
  import microwave_timer_ctrl_pkg::*;
(
  input  logic [3:0] min_i,
  input  logic [3:0] s_tens_i,
  input  logic [3:0] s_ones_i,
  output logic [3:0] min_o,
  output logic [3:0] s_tens_o,
  output logic [3:0] s_ones_o,
  output logic       is_zero_o
);

  always_comb begin
    min_o    = min_i;
    s_tens_o = s_tens_i;
    s_ones_o = s_ones_i;
    if (s_ones_i != 4'd0) begin
      s_ones_o = s_ones_i - 4'd1;
    end else begin
      s_ones_o = BCD_MAX_ONES;
      if (s_tens_i != 4'd0) begin
        s_tens_o = s_tens_i - 4'd1;
      end else begin
        s_tens_o = BCD_MAX_TENS;
        // 0:00 is never decremented by the controller; wrap defensively.
        min_o    = (min_i != 4'd0) ? (min_i - 4'd1) : BCD_MAX_MIN;
      end
    end
  end

  assign is_zero_o = (min_o == 4'd0) && (s_tens_o == 4'd0) && (s_ones_o == 4'd0);

endmodule

`default_nettype wire

// File: rtl/microwave_timer_ctrl.sv
// ============================================================================
// Module   : microwave_timer_ctrl
// Purpose  : Microwave cook-time controller. Keypad digits shift into an m:ss
//            BCD time, which counts down at one step per TICKS_PER_SEC clocks
//            while cooking; drives magnetron enable and a done indicator.
// Ports    : clk, rst_n (async, active-low)
//            key_valid/key_digit - keypad digit strobe
//            start, stop_clear   - control strobes
//            door_closed         - door interlock
//            min/s_tens/s_ones   - BCD time to the display decoder
//            mag_on, done        - registered status outputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microwave_timer_ctrl
  import microwave_timer_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int DONE_CYCLES   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] min,
  output logic       mag_on,
  output logic       done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [3:0]      min_q, min_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            mag_q, mag_d;
  logic            done_q, done_d;

  logic [3:0]      dec_min, dec_tens, dec_ones;
  logic            dec_zero;
  logic            time_zero;
  logic            tick;

  mmss_bcd_dec u_dec (
    .min_i     (min_q),
    .s_tens_i  (tens_q),
    .s_ones_i  (ones_q),
    .min_o     (dec_min),
    .s_tens_o  (dec_tens),
    .s_ones_o  (dec_ones),
    .is_zero_o (dec_zero)
  );

  assign time_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign tick      = (presc_q == PW'(TICKS_PER_SEC - 1));

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    dcnt_d  = dcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (stop_clear) begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (start) begin
          if (door_closed && !time_zero) begin
            state_d = ST_COOK;
            presc_d = '0;
          end
        end else if (key_valid && (key_digit <= BCD_MAX_ONES) &&
                     (ones_q <= BCD_MAX_TENS)) begin
          // Current ones digit becomes the tens digit, so it must be <= 5.
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = key_digit;
        end
      end

      ST_COOK: begin
        if (stop_clear || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          min_d   = dec_min;
          tens_d  = dec_tens;
          ones_d  = dec_ones;
          if (dec_zero) begin
            state_d = ST_DONE;
            dcnt_d  = '0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      ST_PAUSE: begin
        if (stop_clear) begin
          state_d = ST_IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          presc_d = '0;
        end else if (start && door_closed) begin
          state_d = ST_COOK;
        end
      end

      ST_DONE: begin
        if (stop_clear || start) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DW'(DONE_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    mag_d  = (state_d == ST_COOK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      dcnt_q  <= '0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      dcnt_q  <= dcnt_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  assign min    = min_q;
  assign s_tens = tens_q;
  assign s_ones = ones_q;
  assign mag_on = mag_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
// ============================================================================
// Module   : tb_microwave_timer_ctrl
// Purpose  : Scoreboard bench for microwave_timer_ctrl. A seconds-based
//            reference model predicts each cycle's outputs into a queue; a
//            monitor pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microwave_timer_ctrl;

  localparam int T  = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] s_ones, s_tens, min;
  logic       mag_on, done;

  microwave_timer_ctrl #(.TICKS_PER_SEC(T), .DONE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .s_ones(s_ones), .s_tens(s_tens), .min(min), .mag_on(mag_on), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       mag;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: time held as plain seconds.
  typedef enum {M_IDLE, M_COOK, M_PAUSE, M_DONE} mmode_t;
  mmode_t mmode;
  int     secs, phase, dleft;

  task automatic model_reset();
    mmode = M_IDLE; secs = 0; phase = 0; dleft = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.m   = 4'(secs / 60);
    e.t   = 4'((secs % 60) / 10);
    e.o   = 4'(secs % 10);
    e.mag = (mmode == M_COOK);
    e.dn  = (mmode == M_DONE);
    return e;
  endfunction

  task automatic model_step(input bit kv, input int kd, input bit st, input bit sc, input bit dr);
    int o, t;
    case (mmode)
      M_IDLE: begin
        if (sc) secs = 0;
        else if (st) begin
          if (dr && secs != 0) begin mmode = M_COOK; phase = 0; end
        end else if (kv && kd <= 9) begin
          o = secs % 10;
          t = (secs % 60) / 10;
          if (o <= 5) secs = t * 60 + o * 10 + kd;
        end
      end
      M_COOK: begin
        if (sc || !dr) mmode = M_PAUSE;
        else if (phase == T - 1) begin
          phase = 0;
          secs  = secs - 1;
          if (secs == 0) begin mmode = M_DONE; dleft = DC; end
        end else phase = phase + 1;
      end
      M_PAUSE: begin
        if (sc) begin mmode = M_IDLE; secs = 0; phase = 0; end
        else if (st && dr) mmode = M_COOK;
      end
      M_DONE: begin
        if (sc || st) mmode = M_IDLE;
        else begin
          dleft = dleft - 1;
          if (dleft == 0) mmode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic step(input bit kv, input int kd, input bit st, input bit sc, input bit dr);
    @(negedge clk);
    key_valid   = kv;
    key_digit   = 4'(kd);
    start       = st;
    stop_clear  = sc;
    door_closed = dr;
    model_step(kv, kd, st, sc, dr);
    q.push_back(model_out());
  endtask

  task automatic key(input int d);   step(1'b1, d, 1'b0, 1'b0, 1'b1); endtask
  task automatic go();               step(1'b0, 0, 1'b1, 1'b0, 1'b1); endtask
  task automatic clr();              step(1'b0, 0, 1'b0, 1'b1, 1'b1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic door_open(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({min, s_tens, s_ones, mag_on, done} != 14'd0) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d%0d mag=%0b done=%0b, expected 0:00 mag=0 done=0",
               name, min, s_tens, s_ones, mag_on, done);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_mid_cook");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the oldest prediction after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({min, s_tens, s_ones, mag_on, done} != {e.m, e.t, e.o, e.mag, e.dn}) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %0d:%0d%0d mag=%0b done=%0b, expected %0d:%0d%0d mag=%0b done=%0b",
                   cyc, min, s_tens, s_ones, mag_on, done, e.m, e.t, e.o, e.mag, e.dn);
        end
      end
    end
  end

  initial begin
    bit kv, st, sc, dr;
    int kd;
    model_reset();
    #1;
    check_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: key entry and rejection of a shift that would give tens > 5
    key(1); key(3); key(0); idle(1);
    clr(); key(0); key(9); key(0); idle(2);

    // 2: 0:02 countdown to done
    clr(); key(0); key(0); key(2); go(); idle(14);

    // 3: borrow across minutes and tens
    key(1); key(0); key(0); go(); idle(5); clr(); clr();
    key(1); key(0); go(); idle(5); clr(); clr();

    // 4: door opens mid-second, prescaler held across pause
    key(5); go(); idle(4); idle(2); door_open(3); idle(2); go(); idle(6); clr(); clr();

    // 5: stop_clear beats start; start ignored at 0:00 or with door open
    key(5); go(); step(1'b0, 0, 1'b1, 1'b1, 1'b1); clr(); go(); idle(1);
    key(3); step(1'b0, 0, 1'b1, 1'b0, 1'b0); idle(2); clr();

    // DONE cut short by start
    key(1); go(); idle(4); go(); idle(3);

    // 6: reset mid-cook at 3:27
    key(3); key(2); key(7); go(); idle(6);
    do_reset();
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 99) < 6);
      sc = ($urandom_range(0, 99) < 3);
      dr = ($urandom_range(0, 99) < 94);
      kv = !st && ($urandom_range(0, 99) < 30);
      kd = $urandom_range(0, 11);
      step(kv, kd, st, sc, dr);
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
